// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module  : fetch_pkg
//  Purpose : Shared types for the fetch controller and the PC next-address
//            mux: FSM state encoding, PC-source select encoding and the
//            squash-counter width.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // Fetch controller FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        REDIRECT = 2'b10
    } fetch_state_t;

    // Next-PC mux select, shared with the PC mux
    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_t;

    // Squash counter width; holds FLUSH_DEPTH-1 for FLUSH_DEPTH up to 15
    localparam int unsigned c_SQUASH_CNT_W = 4;

    // jalr result wins over the branch/jal target when both are flagged
    function automatic pcsrc_t redirect_src(input logic jalr);
        return jalr ? PCSRC_JALR : PCSRC_BRANCH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
// ============================================================================
//  Module  : fetch_perf_cnt
//  Purpose : Three free-running performance counters for the fetch
//            controller: accepted redirects, stall cycles, running cycles.
//            Counters wrap at 2^CNT_WIDTH and are cleared synchronously by
//            clr (which wins over any increment in the same cycle).
//  Ports   : clk, rst           clock / async active-high reset
//            clr                clear all counters
//            inc_redirect       count one accepted redirect
//            inc_stall          count one stall cycle
//            inc_cycle          count one running cycle
//            perf_redirects, perf_stalls, perf_cycles  counter values
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_redirect,
    input  logic                 inc_stall,
    input  logic                 inc_cycle,
    output logic [CNT_WIDTH-1:0] perf_redirects,
    output logic [CNT_WIDTH-1:0] perf_stalls,
    output logic [CNT_WIDTH-1:0] perf_cycles
);

    logic [CNT_WIDTH-1:0] r_redirects;
    logic [CNT_WIDTH-1:0] r_stalls;
    logic [CNT_WIDTH-1:0] r_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirects <= '0;
            r_stalls    <= '0;
            r_cycles    <= '0;
        end else if (clr) begin
            r_redirects <= '0;
            r_stalls    <= '0;
            r_cycles    <= '0;
        end else begin
            if (inc_redirect) r_redirects <= r_redirects + 1'b1;
            if (inc_stall)    r_stalls    <= r_stalls + 1'b1;
            if (inc_cycle)    r_cycles    <= r_cycles + 1'b1;
        end
    end

    assign perf_redirects = r_redirects;
    assign perf_stalls    = r_stalls;
    assign perf_cycles    = r_cycles;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module  : fetch_ctrl
//  Purpose : Fetch sequencing. Selects the next-PC source each cycle and
//            produces PC-enable, F/D stall and F/D, D/E flush controls from
//            execute-stage redirects, load-use hazards and imem readiness.
//            Outputs are Mealy (state + current inputs) so the PC mux sees
//            a redirect in the same cycle it resolves.
//  Config  : `define FETCH_CTRL_PERF_CNT_EN adds perf_redirects, perf_stalls
//            and perf_cycles (CNT_WIDTH bits each).
//  Ports   : clk, rst                 clock / async active-high reset
//            trigger                  run enable (low holds core at PC 0)
//            valid_e, branch_taken_e,
//            jal_e, jalr_e            execute-stage redirect sources
//            load_use                 load-use hazard from hazard unit
//            imem_ready               instruction memory data valid
//            pcsrc                    next-PC select (00 +4, 01 imm, 10 jalr)
//            pc_en                    PC register write enable
//            stall_d                  hold F/D register
//            flush_d, flush_e         clear F/D, D/E registers
//            running                  FSM active (RUN/REDIRECT) with trigger
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH   = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       valid_e,
    input  logic       branch_taken_e,
    input  logic       jal_e,
    input  logic       jalr_e,
    input  logic       load_use,
    input  logic       imem_ready,
    output logic [1:0] pcsrc,
    output logic       pc_en,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       running
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_redirects,
    output logic [CNT_WIDTH-1:0] perf_stalls,
    output logic [CNT_WIDTH-1:0] perf_cycles
`endif
);

    localparam logic [c_SQUASH_CNT_W-1:0] c_CNT_LOAD =
        c_SQUASH_CNT_W'(FLUSH_DEPTH - 1);

    fetch_state_t                r_state;
    fetch_state_t                w_next_state;
    logic [c_SQUASH_CNT_W-1:0]   r_cnt;
    logic [c_SQUASH_CNT_W-1:0]   w_next_cnt;
    pcsrc_t                      w_pcsrc;
    logic                        w_redirect;
    logic                        w_redirect_acc;

    assign w_redirect = valid_e & (branch_taken_e | jal_e | jalr_e);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        // Idle/reset output set; active states override below
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_pcsrc        = PCSRC_PLUS4;
        w_redirect_acc = 1'b0;
        pc_en          = 1'b0;
        stall_d        = 1'b0;
        flush_d        = 1'b1;
        flush_e        = 1'b1;
        running        = 1'b0;

        case (r_state)
            IDLE: begin
                // First fetch after trigger comes from PC 0, so the PC is
                // not advanced here.
                if (trigger) begin
                    w_next_state = RUN;
                end
            end

            RUN, REDIRECT: begin
                if (!trigger) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    running = 1'b1;
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                    // Redirects are only honoured in RUN; in REDIRECT they
                    // come from wrong-path instructions being squashed.
                    // A redirect writes the PC even without imem_ready: the
                    // pending fetch is dropped by flush_d.
                    if (r_state == RUN && w_redirect) begin
                        w_redirect_acc = 1'b1;
                        w_pcsrc        = redirect_src(jalr_e);
                        pc_en          = 1'b1;
                        flush_d        = 1'b1;
                        flush_e        = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            w_next_state = REDIRECT;
                            w_next_cnt   = c_CNT_LOAD;
                        end
                    end else if (load_use) begin
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (!imem_ready) begin
                        stall_d = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        // Squash window only advances on real fetches
                        if (r_state == REDIRECT) begin
                            if (r_cnt <= c_SQUASH_CNT_W'(1)) begin
                                w_next_cnt   = '0;
                                w_next_state = RUN;
                            end else begin
                                w_next_cnt = r_cnt - 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign pcsrc = w_pcsrc;

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic w_perf_clr;

    // Counters restart whenever the controller drops back to IDLE
    assign w_perf_clr = (r_state != IDLE) && (w_next_state == IDLE);

    fetch_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .clr            (w_perf_clr),
        .inc_redirect   (w_redirect_acc),
        .inc_stall      (stall_d),
        .inc_cycle      (running),
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls),
        .perf_cycles    (perf_cycles)
    );
`else
    logic w_unused_redirect_acc;
    assign w_unused_redirect_acc = w_redirect_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module  : tb_fetch_ctrl
//  Purpose : Self-checking bench for fetch_ctrl (FLUSH_DEPTH=2). Expected
//            output vectors are queued as each stimulus is applied and
//            compared when the outputs are sampled on the falling edge.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger, valid_e, branch_taken_e, jal_e, jalr_e;
    logic       load_use, imem_ready;
    logic [1:0] pcsrc;
    logic       pc_en, stall_d, flush_d, flush_e, running;
`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [31:0] perf_redirects, perf_stalls, perf_cycles;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] ex;   // {pcsrc[1:0], pc_en, stall_d, flush_d, flush_e, running}
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    // Expected-output shorthands
    localparam logic [6:0] c_E_IDLE  = 7'b00_0_0_1_1_0;
    localparam logic [6:0] c_E_RUN   = 7'b00_1_0_0_0_1;
    localparam logic [6:0] c_E_BR    = 7'b01_1_0_1_1_1;
    localparam logic [6:0] c_E_JALR  = 7'b10_1_0_1_1_1;
    localparam logic [6:0] c_E_LU    = 7'b00_0_1_0_1_1;
    localparam logic [6:0] c_E_WAIT  = 7'b00_0_1_0_0_1;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .FLUSH_DEPTH (2)
`ifdef FETCH_CTRL_PERF_CNT_EN
        ,
        .CNT_WIDTH   (32)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .valid_e        (valid_e),
        .branch_taken_e (branch_taken_e),
        .jal_e          (jal_e),
        .jalr_e         (jalr_e),
        .load_use       (load_use),
        .imem_ready     (imem_ready),
        .pcsrc          (pcsrc),
        .pc_en          (pc_en),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .running        (running)
`ifdef FETCH_CTRL_PERF_CNT_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls),
        .perf_cycles    (perf_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {trigger, valid_e, branch_taken_e, jal_e, jalr_e, load_use, imem_ready} = in;
    endtask

    // Pop the oldest expectation and compare against the live outputs
    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".pcsrc"},   {30'd0, pcsrc},   {30'd0, e.ex[6:5]});
        chk({e.tag, ".pc_en"},   {31'd0, pc_en},   {31'd0, e.ex[4]});
        chk({e.tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, e.ex[3]});
        chk({e.tag, ".flush_d"}, {31'd0, flush_d}, {31'd0, e.ex[2]});
        chk({e.tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, e.ex[1]});
        chk({e.tag, ".running"}, {31'd0, running}, {31'd0, e.ex[0]});
    endtask

    // Inputs: {trigger, valid_e, branch_taken_e, jal_e, jalr_e, load_use, imem_ready}
    // Apply after a rising edge, check at the falling edge, return after the
    // next rising edge.
    task automatic step(input logic [6:0] in, input logic [6:0] ex, input string tag);
        exp_t e;
        drive(in);
        e.ex  = ex;
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(7'b1000001);
        @(negedge clk);
        begin
            exp_t e;
            e.ex = c_E_IDLE; e.tag = "in_reset";
            exp_q.push_back(e);
        end
        compare_out();
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_rst_cyc", perf_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) step(7'b0000001, c_E_IDLE, "idle_trig0");
        step(7'b1000001, c_E_IDLE, "boot_edge");
        step(7'b1000001, c_E_RUN,  "boot_run");
        step(7'b1110001, c_E_BR,   "branch");
        step(7'b1101001, c_E_RUN,  "squash_jal");
        step(7'b1000001, c_E_RUN,  "post_squash");
        step(7'b1101101, c_E_JALR, "jalr_prio");
        step(7'b1000001, c_E_RUN,  "squash2");
        step(7'b1001101, c_E_RUN,  "novalid");
        step(7'b1000011, c_E_LU,   "load_use");
        step(7'b1110011, c_E_BR,   "lu_vs_br");
        step(7'b1000001, c_E_RUN,  "squash3");
        for (int i = 0; i < 3; i++) step(7'b1000000, c_E_WAIT, "imem_wait");
        step(7'b1000001, c_E_RUN,  "imem_back");
        step(7'b1110001, c_E_BR,   "branch2");
        for (int i = 0; i < 3; i++) step(7'b1110000, c_E_WAIT, "redir_wait");
        // Squash counter must have held: jal still ignored here
        step(7'b1101001, c_E_RUN,  "redir_held");
        step(7'b1101000, c_E_BR,   "redir_no_rdy");

        // trigger drops mid-REDIRECT
        drive(7'b0000001);
        begin
            exp_t e;
            e.ex = c_E_IDLE; e.tag = "abort";
            exp_q.push_back(e);
        end
        @(negedge clk);
        compare_out();
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_redir_pre", perf_redirects, 32'd5);
        chk("perf_stall_pre", perf_stalls,    32'd7);
        chk("perf_cyc_pre",   perf_cycles,    32'd20);
`endif
        @(posedge clk);
        #1;
        step(7'b0000001, c_E_IDLE, "abort_idle");
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_redir_clr", perf_redirects, 32'd0);
        chk("perf_stall_clr", perf_stalls,    32'd0);
        chk("perf_cyc_clr",   perf_cycles,    32'd0);
`endif
        step(7'b1000001, c_E_IDLE, "reboot_edge");
        step(7'b1000001, c_E_RUN,  "reboot_run");

        // Asynchronous reset mid-cycle
        drive(7'b1000001);
        begin
            exp_t e;
            e.ex = c_E_RUN; e.tag = "pre_arst";
            exp_q.push_back(e);
        end
        @(negedge clk);
        compare_out();
        #2;
        rst = 1'b1;
        #1;
        begin
            exp_t e;
            e.ex = c_E_IDLE; e.tag = "arst";
            exp_q.push_back(e);
        end
        compare_out();
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_arst_cyc", perf_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(7'b0000001, c_E_IDLE, "post_arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
